// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: DHT11 read sequencer with inter-read gap, auto-poll, timeouts, checksum validation, retries and last-good sample hold
module sensor_poll_scheduler #(
  parameter int GAP_CYCLES   = 50_000_000,
  parameter int POLL_CYCLES  = 100_000_000,
  parameter int DONE_TIMEOUT = 8_000_000,
  parameter int BUSY_TIMEOUT = 16,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       auto_en,
  input  logic       req,
  output logic       busy,
  output logic       data_valid,
  output logic       fail,
  output logic [2:0] attempts,
  output logic [7:0] hum_int,
  output logic [7:0] hum_float,
  output logic [7:0] temp_int,
  output logic [7:0] temp_float,
  output logic       dec_enable,
  output logic       dec_reset,
  input  logic       dec_hold,
  input  logic       dec_error,
  input  logic [7:0] dec_hum_int,
  input  logic [7:0] dec_hum_float,
  input  logic [7:0] dec_temp_int,
  input  logic [7:0] dec_temp_float,
  input  logic [7:0] dec_checksum
);
  localparam int M1 = (GAP_CYCLES > POLL_CYCLES) ? GAP_CYCLES : POLL_CYCLES;
  localparam int M2 = (M1 > DONE_TIMEOUT) ? M1 : DONE_TIMEOUT;
  localparam int MX = (M2 > BUSY_TIMEOUT) ? M2 : BUSY_TIMEOUT;
  localparam int W = $clog2(MX) + 1;
  localparam logic [W-1:0] GAP_END  = W'(GAP_CYCLES - 1);
  localparam logic [W-1:0] POLL_END = W'(POLL_CYCLES - 1);
  localparam logic [W-1:0] DONE_END = W'(DONE_TIMEOUT - 1);
  localparam logic [W-1:0] BUSY_END = W'(BUSY_TIMEOUT - 1);
  localparam logic [2:0] RMAX = 3'(MAX_RETRIES);
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_CHECK, S_FAILED} state_t;
  state_t state, next_state;
  logic [W-1:0] gap_cnt, poll_cnt, tmo_cnt;
  logic [2:0] retry;
  logic sticky_err, had_read;
  logic [9:0] sum;
  logic good, trigger, gap_done, retry_left, in_wait, leave_wait;
  assign sum = 10'(dec_hum_int) + 10'(dec_hum_float) + 10'(dec_temp_int) + 10'(dec_temp_float);
  assign good = ~sticky_err & (((sum ^ {2'b00, dec_checksum}) & 10'h0ff) == 10'd0)
              & (|{dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum});
  assign trigger = (req & ~busy) | (auto_en & (poll_cnt >= POLL_END));
  // No read has finished since reset, so the first start need not wait out a gap
  assign gap_done = ~had_read | (gap_cnt == GAP_END);
  assign retry_left = retry < RMAX;
  assign in_wait = (state == S_WAIT_BUSY) | (state == S_WAIT_DONE);
  assign leave_wait = in_wait & (next_state != state);
  always_ff @(posedge clock)
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      next_state = trigger ? S_GAP : S_IDLE;
      S_GAP:       next_state = gap_done ? S_START : S_GAP;
      S_START:     next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: next_state = dec_hold ? S_WAIT_DONE : (tmo_cnt == BUSY_END) ? S_FAILED : S_WAIT_BUSY;
      S_WAIT_DONE: next_state = (~dec_hold & ~dec_error) ? S_CHECK : (tmo_cnt == DONE_END) ? S_FAILED : S_WAIT_DONE;
      S_CHECK:     next_state = good ? S_IDLE : S_FAILED;
      S_FAILED:    next_state = retry_left ? S_GAP : S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end
  always_comb dec_reset = state == S_START;
  always_ff @(posedge clock) begin
    if (!reset) begin
      dec_enable <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      fail       <= 1'b0;
      attempts   <= 3'd0;
      hum_int    <= 8'd0;
      hum_float  <= 8'd0;
      temp_int   <= 8'd0;
      temp_float <= 8'd0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      tmo_cnt    <= '0;
      retry      <= 3'd0;
      sticky_err <= 1'b0;
      had_read   <= 1'b0;
    end else begin
      dec_enable <= 1'b1;
      data_valid <= (state == S_CHECK) & good;
      fail       <= (state == S_FAILED) & ~retry_left;
      poll_cnt   <= (~auto_en | (state == S_START)) ? '0 : (poll_cnt == POLL_END) ? poll_cnt : poll_cnt + W'(1);
      gap_cnt    <= (leave_wait | (state == S_FAILED)) ? '0 : (gap_cnt == GAP_END) ? gap_cnt : gap_cnt + W'(1);
      tmo_cnt    <= (in_wait & (next_state == state)) ? tmo_cnt + W'(1) : '0;
      had_read   <= had_read | leave_wait;
      // Decoder zeros its bytes before dropping hold after an error, so the error must be remembered
      sticky_err <= (state == S_START) ? 1'b0 : sticky_err | ((state == S_WAIT_DONE) & dec_error);
      if ((state == S_IDLE) & trigger) begin
        busy  <= 1'b1;
        retry <= 3'd0;
      end
      if ((state == S_FAILED) & retry_left) retry <= retry + 3'd1;
      if ((state == S_CHECK) & good) begin
        hum_int    <= dec_hum_int;
        hum_float  <= dec_hum_float;
        temp_int   <= dec_temp_int;
        temp_float <= dec_temp_float;
      end
      if (((state == S_CHECK) & good) | ((state == S_FAILED) & ~retry_left)) begin
        busy     <= 1'b0;
        attempts <= retry + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb_sensor_poll_scheduler: table-driven scoreboard bench with a behavioural DHT11 decoder model
module tb_sensor_poll_scheduler;
  localparam logic [1:0] K_GOOD = 2'd0, K_ERR = 2'd1, K_HANG = 2'd2, K_NOHOLD = 2'd3;
  localparam logic [39:0] F1     = {8'd45, 8'd0, 8'd23, 8'd5, 8'd73};
  localparam logic [39:0] F1_BAD = {8'd45, 8'd0, 8'd23, 8'd5, 8'd74};
  localparam logic [39:0] F2     = {8'd50, 8'd10, 8'd20, 8'd3, 8'd83};
  localparam logic [39:0] F3     = {8'd60, 8'd1, 8'd22, 8'd0, 8'd83};
  localparam logic [39:0] F3_BAD = {8'd60, 8'd1, 8'd22, 8'd0, 8'd84};
  localparam logic [39:0] FW     = {8'd200, 8'd100, 8'd0, 8'd0, 8'd44};
  localparam logic [39:0] F_AUTO = {8'd30, 8'd0, 8'd25, 8'd0, 8'd55};
  typedef struct packed {logic [1:0] kind; logic [39:0] frame;} resp_t;
  typedef struct {resp_t r[3]; logic ok; logic [2:0] att; logic gap_chk;} vec_t;
  typedef struct packed {logic ok; logic [2:0] att; logic [31:0] data;} exp_t;
  logic clock = 1'b0, reset = 1'b0, auto_en = 1'b0, req = 1'b0;
  logic busy, data_valid, fail, dec_enable, dec_reset;
  logic [2:0] attempts;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic dec_hold = 1'b0, dec_error = 1'b0;
  logic [7:0] dec_hum_int = 8'd0, dec_hum_float = 8'd0, dec_temp_int = 8'd0, dec_temp_float = 8'd0, dec_checksum = 8'd0;
  logic release_hold = 1'b0;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, starts = 0, last_end = 0, min_gap = 0;
  logic [31:0] last_good = 32'd0;
  resp_t resp_q[$];
  exp_t exp_q[$];
  int start_cycs[$];
  resp_t mr;
  exp_t me;
  always #5 clock = ~clock;
  sensor_poll_scheduler #(.GAP_CYCLES(100), .POLL_CYCLES(400), .DONE_TIMEOUT(1000), .BUSY_TIMEOUT(16), .MAX_RETRIES(2)) dut (
    .clock(clock), .reset(reset), .auto_en(auto_en), .req(req), .busy(busy), .data_valid(data_valid),
    .fail(fail), .attempts(attempts), .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int),
    .temp_float(temp_float), .dec_enable(dec_enable), .dec_reset(dec_reset), .dec_hold(dec_hold),
    .dec_error(dec_error), .dec_hum_int(dec_hum_int), .dec_hum_float(dec_hum_float),
    .dec_temp_int(dec_temp_int), .dec_temp_float(dec_temp_float), .dec_checksum(dec_checksum)
  );
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always begin
    @(negedge clock);
    if (release_hold) dec_hold = 1'b0;
    if (dec_reset) begin
      starts++;
      start_cycs.push_back(cyc);
      if (cyc - last_end < min_gap) min_gap = cyc - last_end;
      dec_hold = 1'b0;
      dec_error = 1'b0;
      {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum} = 40'd0;
      if (resp_q.size() > 0) mr = resp_q.pop_front();
      else mr = {K_GOOD, F_AUTO};
      case (mr.kind)
        K_GOOD: begin
          repeat (2) @(negedge clock);
          dec_hold = 1'b1;
          repeat (20) @(negedge clock);
          {dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum} = mr.frame;
          dec_hold = 1'b0;
          last_end = cyc;
        end
        K_ERR: begin
          dec_hold = 1'b1;
          repeat (4) @(negedge clock);
          dec_error = 1'b1;
          repeat (3) @(negedge clock);
          dec_error = 1'b0;
          @(negedge clock);
          dec_hold = 1'b0;
          last_end = cyc;
        end
        K_HANG: dec_hold = 1'b1;
        default: ;
      endcase
    end
  end
  always @(negedge clock)
    if (data_valid || fail) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result dv=%0b fail=%0b at cycle %0d", data_valid, fail, cyc);
      end else begin
        me = exp_q.pop_front();
        chk("outcome", {30'd0, data_valid, fail}, me.ok ? 32'd2 : 32'd1);
        chk("attempts", 32'(attempts), 32'(me.att));
        chk("sample", {hum_int, hum_float, temp_int, temp_float}, me.data);
        chk("busy_at_result", 32'(busy), 32'd0);
      end
    end
  function automatic vec_t mkv(input resp_t a, input resp_t b, input resp_t c, input logic ok, input logic [2:0] att, input logic g);
    vec_t v;
    v.r[0] = a;
    v.r[1] = b;
    v.r[2] = c;
    v.ok = ok;
    v.att = att;
    v.gap_chk = g;
    return v;
  endfunction
  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("result_in_time", 32'(done_cnt >= target), 32'd1);
  endtask
  task automatic drop_hold();
    release_hold = 1'b1;
    repeat (2) @(negedge clock);
    release_hold = 1'b0;
  endtask
  task automatic pulse_req();
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
  endtask
  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pulses"}, {30'd0, data_valid, fail}, 32'd0);
    chk({tag, "_attempts"}, 32'(attempts), 32'd0);
    chk({tag, "_sample"}, {hum_int, hum_float, temp_int, temp_float}, 32'd0);
    chk({tag, "_dec_enable"}, 32'(dec_enable), 32'd0);
    chk({tag, "_dec_reset"}, 32'(dec_reset), 32'd0);
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    int s0, t0, d0, a;
    for (int i = 0; i < 3; i++) resp_q.push_back(v.r[i]);
    a = int'(v.att);
    e.ok = v.ok;
    e.att = v.att;
    e.data = v.ok ? v.r[a-1].frame[39:8] : last_good;
    last_good = e.data;
    exp_q.push_back(e);
    s0 = starts;
    t0 = cyc;
    d0 = done_cnt;
    min_gap = 1_000_000;
    pulse_req();
    wait_done(d0 + 1, 6000);
    @(negedge clock);
    chk("pulse_one_cycle", {30'd0, data_valid, fail}, 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("dec_reset_count", 32'(starts - s0), 32'(a));
    if (v.gap_chk) chk("retry_gap_ge_100", 32'(min_gap >= 100), 32'd1);
    if (v.r[0].kind == K_HANG) chk("hang_duration", 32'((cyc - t0) >= 3000 && (cyc - t0) <= 3500), 32'd1);
    resp_q.delete();
    drop_hold();
    repeat (3) @(negedge clock);
  endtask
  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not complete");
  end
  initial begin
    vec_t vecs[9];
    int s0, d0, n, sp1, sp2;
    vecs[0] = mkv({K_GOOD, F1}, {K_GOOD, F1}, {K_GOOD, F1}, 1'b1, 3'd1, 1'b0);
    vecs[1] = mkv({K_GOOD, F1_BAD}, {K_GOOD, F1}, {K_GOOD, F1}, 1'b1, 3'd2, 1'b1);
    vecs[2] = mkv({K_ERR, F1}, {K_ERR, F1}, {K_ERR, F1}, 1'b0, 3'd3, 1'b1);
    vecs[3] = mkv({K_GOOD, F2}, {K_GOOD, F2}, {K_GOOD, F2}, 1'b1, 3'd1, 1'b0);
    vecs[4] = mkv({K_GOOD, F3_BAD}, {K_ERR, F3}, {K_GOOD, F3}, 1'b1, 3'd3, 1'b1);
    vecs[5] = mkv({K_GOOD, FW}, {K_GOOD, FW}, {K_GOOD, FW}, 1'b1, 3'd1, 1'b0);
    vecs[6] = mkv({K_GOOD, 40'd0}, {K_GOOD, 40'd0}, {K_GOOD, 40'd0}, 1'b0, 3'd3, 1'b1);
    vecs[7] = mkv({K_NOHOLD, F1}, {K_NOHOLD, F1}, {K_NOHOLD, F1}, 1'b0, 3'd3, 1'b0);
    vecs[8] = mkv({K_HANG, F1}, {K_HANG, F1}, {K_HANG, F1}, 1'b0, 3'd3, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    chk("dec_enable_after_reset", 32'(dec_enable), 32'd1);
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 3'd1, F_AUTO[39:8]});
    last_good = F_AUTO[39:8];
    s0 = starts;
    d0 = done_cnt;
    start_cycs.delete();
    auto_en = 1'b1;
    wait_done(d0 + 1, 1000);
    n = 0;
    while (!busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("auto_second_busy", 32'(busy), 32'd1);
    pulse_req();
    wait_done(d0 + 3, 1500);
    @(negedge clock);
    auto_en = 1'b0;
    repeat (500) @(negedge clock);
    chk("auto_dec_reset_count", 32'(starts - s0), 32'd3);
    chk("auto_result_count", 32'(done_cnt - d0), 32'd3);
    sp1 = start_cycs[1] - start_cycs[0];
    sp2 = start_cycs[2] - start_cycs[1];
    chk("auto_spacing_1", 32'(sp1 >= 400 && sp1 <= 410), 32'd1);
    chk("auto_spacing_2", 32'(sp2 >= 400 && sp2 <= 410), 32'd1);
    resp_q.push_back({K_HANG, F1});
    s0 = starts;
    d0 = done_cnt;
    pulse_req();
    n = 0;
    while (!dec_hold && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("midread_hold_seen", 32'(dec_hold), 32'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_zero_outputs("midread_reset");
    reset = 1'b1;
    resp_q.delete();
    drop_hold();
    repeat (600) @(negedge clock);
    chk("midread_no_restart", 32'(starts - s0), 32'd1);
    chk("midread_no_result", 32'(done_cnt - d0), 32'd0);
    last_good = 32'd0;
    run_vec(vecs[3]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
